// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and its multiply/divide sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MF  = 4'b1111;

    localparam logic [2:0] CLS_RTYPE  = 3'b000;
    localparam logic [2:0] CLS_ADDI   = 3'b001;
    localparam logic [2:0] CLS_BRANCH = 3'b010;
    localparam logic [2:0] CLS_SLTI   = 3'b011;
    localparam logic [2:0] CLS_MEM    = 3'b100;
    localparam logic [2:0] CLS_ANDI   = 3'b101;
    localparam logic [2:0] CLS_ORI    = 3'b110;
    localparam logic [2:0] CLS_XORI   = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b10;
    localparam logic [1:0] HILO_LO   = 2'b01;

    // Values match funct[1:0] of the four mult/div instructions.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_kind_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_FIX  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_control_mdu_if.sv
// Bundle between the ID/EX register (master) and the ALU control/MDU block (slave).
interface alu_control_mdu_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [3:0]        op;
    logic              op_valid;
    logic [1:0]        hilo_sel;
    logic              illegal;
    logic              mdu_busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_by_zero;

    modport master (
        output in_valid, alu_op, funct, rs_val, rt_val,
        input  in_ready, op, op_valid, hilo_sel, illegal, mdu_busy, hi, lo, div_by_zero
    );

    modport slave (
        input  in_valid, alu_op, funct, rs_val, rt_val,
        output in_ready, op, op_valid, hilo_sel, illegal, mdu_busy, hi, lo, div_by_zero
    );
endinterface

// File: rtl/alu_control_mdu_seq.sv
// Iterative multiply/divide sequencer: magnitude shift-add / restoring divide, then sign fix-up into HI/LO.
module mdu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  md_kind_t          kind,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    seq_state_t state, state_next;

    logic [CNT_W-1:0]    count;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic                dz;
    logic [DATA_W-1:0]   dividend;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;

    logic                sgn_a, sgn_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic                div_take;
    logic [DATA_W-1:0]   div_diff;
    logic [DATA_W-1:0]   step_hi, step_lo;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= SEQ_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEQ_IDLE: if (start) state_next = SEQ_RUN;
            SEQ_RUN:  if (count == LAST) state_next = SEQ_FIX;
            SEQ_FIX:  state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    assign busy  = (state != SEQ_IDLE);
    assign sgn_a = (kind == MD_MULT || kind == MD_DIV) && a[DATA_W-1];
    assign sgn_b = (kind == MD_MULT || kind == MD_DIV) && b[DATA_W-1];

    // {acc_hi, acc_lo} is the product (shifting right) or remainder:quotient (shifting left).
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_sh   = {acc_hi, acc_lo[DATA_W-1]};
        div_take = (div_sh >= {1'b0, mag_b});
        div_diff = div_sh[DATA_W-1:0] - mag_b;
        if (is_div) begin
            step_hi = div_take ? div_diff : div_sh[DATA_W-1:0];
            step_lo = {acc_lo[DATA_W-2:0], div_take};
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quot_fix = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            dividend    <= '0;
            mag_b       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        count       <= '0;
                        is_div      <= kind[1];
                        neg_q       <= sgn_a ^ sgn_b;
                        neg_r       <= sgn_a;
                        dz          <= kind[1] && (b == '0);
                        dividend    <= a;
                        mag_b       <= sgn_b ? -b : b;
                        acc_hi      <= '0;
                        acc_lo      <= sgn_a ? -a : a;
                        div_by_zero <= 1'b0;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                SEQ_RUN: begin
                    count  <= count + 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                SEQ_FIX: begin
                    if (is_div && dz) begin
                        hi <= dividend;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control: registered op decode, HI/LO moves, and handshake stalling on the mult/div sequencer.
module alu_control_mdu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_control_mdu_if.slave bus
);
    logic       accept;
    logic       busy;
    logic [3:0] op_d, op_q;
    logic       op_valid_d, op_valid_q;
    logic [1:0] sel_d, sel_q;
    logic       illegal_d, illegal_q;
    logic       md_start, wr_hi, wr_lo;

    logic [DATA_W-1:0] hi, lo;
    logic              div_by_zero;

    assign accept = bus.in_valid && !busy;

    always_comb begin
        op_d       = ALU_ADD;
        op_valid_d = 1'b0;
        sel_d      = HILO_NONE;
        illegal_d  = 1'b0;
        md_start   = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        if (accept) begin
            op_valid_d = 1'b1;
            if (bus.alu_op == CLS_RTYPE) begin
                case (bus.funct)
                    FN_ADD, FN_ADDU: op_d = ALU_ADD;
                    FN_SUB, FN_SUBU: op_d = ALU_SUB;
                    FN_AND:          op_d = ALU_AND;
                    FN_OR:           op_d = ALU_OR;
                    FN_XOR:          op_d = ALU_XOR;
                    FN_NOR:          op_d = ALU_NOR;
                    FN_SLT:          op_d = ALU_SLT;
                    FN_SLL:          op_d = ALU_SLL;
                    FN_SRL:          op_d = ALU_SRL;
                    FN_SRA:          op_d = ALU_SRA;
                    FN_MFHI: begin
                        op_d  = ALU_MF;
                        sel_d = HILO_HI;
                    end
                    FN_MFLO: begin
                        op_d  = ALU_MF;
                        sel_d = HILO_LO;
                    end
                    FN_MTHI: begin
                        op_valid_d = 1'b0;
                        wr_hi      = 1'b1;
                    end
                    FN_MTLO: begin
                        op_valid_d = 1'b0;
                        wr_lo      = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        op_valid_d = 1'b0;
                        md_start   = 1'b1;
                    end
                    default: begin
                        op_valid_d = 1'b0;
                        illegal_d  = 1'b1;
                    end
                endcase
            end else begin
                case (bus.alu_op)
                    CLS_ADDI, CLS_MEM: op_d = ALU_ADD;
                    CLS_BRANCH:        op_d = ALU_SUB;
                    CLS_SLTI:          op_d = ALU_SLT;
                    CLS_ANDI:          op_d = ALU_AND;
                    CLS_ORI:           op_d = ALU_OR;
                    CLS_XORI:          op_d = ALU_XOR;
                    default:           op_d = ALU_ADD;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            op_valid_q <= 1'b0;
            sel_q      <= HILO_NONE;
            illegal_q  <= 1'b0;
        end else begin
            op_valid_q <= op_valid_d;
            sel_q      <= sel_d;
            illegal_q  <= illegal_d;
            if (accept) op_q <= op_d;
        end
    end

    mdu_seq #(
        .DATA_W (DATA_W)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (md_start),
        .kind        (md_kind_t'(bus.funct[1:0])),
        .a           (bus.rs_val),
        .b           (bus.rt_val),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (bus.rs_val),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    assign bus.in_ready    = !busy;
    assign bus.mdu_busy    = busy;
    assign bus.op          = op_q;
    assign bus.op_valid    = op_valid_q;
    assign bus.hilo_sel    = sel_q;
    assign bus.illegal     = illegal_q;
    assign bus.hi          = hi;
    assign bus.lo          = lo;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Scoreboard bench: stimulus pushes expected responses from an arithmetic reference model; a monitor pops and compares.
module tb_alu_control_mdu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_mdu_if #(.DATA_W(W)) bus();

    alu_control_mdu #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         is_mdu;
        logic [3:0] op;
        bit         op_valid;
        logic [1:0] sel;
        bit         ill;
        logic [31:0] hi;
        logic [31:0] lo;
        bit         dbz;
        int         when;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_dbz = 1'b0;
    logic [3:0]  rop [int];
    logic [3:0]  cop [8];
    logic [5:0]  legal_fn [22];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: decode by lookup, mult/div by 64-bit integer arithmetic.
    task automatic model(input logic [2:0] a, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [63:0] p, r;
        longint x, y;
        e = '{is_mdu: 0, op: 4'b0101, op_valid: 0, sel: 2'b00, ill: 0, hi: '0, lo: '0, dbz: 0, when: cyc + 1};
        if (a != 3'd0) begin
            e.op = cop[a];
            e.op_valid = 1;
        end else if (rop.exists(int'(f))) begin
            e.op = rop[int'(f)];
            e.op_valid = 1;
        end else if (f == 6'b010000 || f == 6'b010010) begin
            e.op = 4'b1111;
            e.op_valid = 1;
            e.sel = (f == 6'b010000) ? 2'b10 : 2'b01;
        end else if (f == 6'b010001) begin
            m_hi = rs;
            return;
        end else if (f == 6'b010011) begin
            m_lo = rs;
            return;
        end else if (f[5:2] == 4'b0110) begin
            e.is_mdu = 1;
            e.when = cyc + 1 + W + 1;
            m_dbz = 0;
            if (f[1] && rt == 0) begin
                m_hi = rs;
                m_lo = '1;
                m_dbz = 1;
            end else if (f[1]) begin
                x = f[0] ? longint'({32'b0, rs}) : longint'($signed(rs));
                y = f[0] ? longint'({32'b0, rt}) : longint'($signed(rt));
                p = 64'(x / y);
                r = 64'(x % y);
                m_lo = p[31:0];
                m_hi = r[31:0];
            end else begin
                x = f[0] ? longint'({32'b0, rs}) : longint'($signed(rs));
                y = f[0] ? longint'({32'b0, rt}) : longint'($signed(rt));
                p = 64'(x * y);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
        end else begin
            e.ill = 1;
        end
        e.hi = m_hi;
        e.lo = m_lo;
        e.dbz = m_dbz;
        q.push_back(e);
    endtask

    // Monitor: pops on a decode strobe or on the falling edge of mdu_busy.
    bit prev_busy = 0;
    int busy_len = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready_vs_busy", {63'b0, bus.in_ready}, {63'b0, !bus.mdu_busy});
            if (bus.mdu_busy) busy_len++;
            if (bus.op_valid || bus.illegal) begin
                if (q.size() == 0) check("unexpected_decode", 1, 0);
                else begin
                    e = q.pop_front();
                    check("event_kind_dec", {63'b0, e.is_mdu}, 0);
                    check("op_valid", {63'b0, bus.op_valid}, {63'b0, e.op_valid});
                    check("illegal", {63'b0, bus.illegal}, {63'b0, e.ill});
                    check("op", {60'b0, bus.op}, {60'b0, e.op});
                    check("hilo_sel", {62'b0, bus.hilo_sel}, {62'b0, e.sel});
                    check("hi_arch", {32'b0, bus.hi}, {32'b0, e.hi});
                    check("lo_arch", {32'b0, bus.lo}, {32'b0, e.lo});
                    check("dec_cycle", 64'(cyc), 64'(e.when));
                end
            end
            if (prev_busy && !bus.mdu_busy) begin
                if (q.size() == 0) check("unexpected_mdu_done", 1, 0);
                else begin
                    e = q.pop_front();
                    check("event_kind_mdu", {63'b0, e.is_mdu}, 1);
                    check("mdu_hi", {32'b0, bus.hi}, {32'b0, e.hi});
                    check("mdu_lo", {32'b0, bus.lo}, {32'b0, e.lo});
                    check("div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, e.dbz});
                    check("busy_cycles", 64'(busy_len), 64'(W + 1));
                    check("mdu_cycle", 64'(cyc), 64'(e.when));
                end
                busy_len = 0;
            end
            prev_busy = bus.mdu_busy;
        end else begin
            prev_busy = 0;
            busy_len = 0;
        end
    end

    task automatic issue(input logic [2:0] a, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input bit push);
        int n = 0;
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.alu_op = a;
        bus.funct = f;
        bus.rs_val = rs;
        bus.rt_val = rt;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        if (push) model(a, f, rs, rt);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.alu_op = 3'($urandom);
        bus.funct = 6'($urandom);
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", 64'(q.size()), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [2:0] a;
        logic [5:0] f;
        rop[32'b100000] = 4'b0101; rop[32'b100001] = 4'b0101;
        rop[32'b100010] = 4'b0110; rop[32'b100011] = 4'b0110;
        rop[32'b100100] = 4'b0000; rop[32'b100101] = 4'b0001;
        rop[32'b100110] = 4'b0010; rop[32'b100111] = 4'b0011;
        rop[32'b101010] = 4'b0111; rop[32'b000000] = 4'b1001;
        rop[32'b000010] = 4'b1000; rop[32'b000011] = 4'b1010;
        cop = '{4'b0000, 4'b0101, 4'b0110, 4'b0111, 4'b0101, 4'b0000, 4'b0001, 4'b0010};
        legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02,
                     6'h03, 6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h18, 6'h1A};

        bus.in_valid = 1'b0;
        bus.alu_op = '0;
        bus.funct = '0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (3) @(negedge clk);
        check("rst_op", {60'b0, bus.op}, 0);
        check("rst_op_valid", {63'b0, bus.op_valid}, 0);
        check("rst_hilo_sel", {62'b0, bus.hilo_sel}, 0);
        check("rst_illegal", {63'b0, bus.illegal}, 0);
        check("rst_busy", {63'b0, bus.mdu_busy}, 0);
        check("rst_in_ready", {63'b0, bus.in_ready}, 1);
        check("rst_hi", {32'b0, bus.hi}, 0);
        check("rst_lo", {32'b0, bus.lo}, 0);
        check("rst_dbz", {63'b0, bus.div_by_zero}, 0);
        #1 rst_n = 1'b1;

        issue(3'b000, 6'b100100, 0, 0, 1);
        issue(3'b000, 6'b100111, 0, 0, 1);
        issue(3'b000, 6'b000011, 0, 0, 1);
        issue(3'b110, 6'b101010, 0, 0, 1);
        issue(3'b010, 6'b000000, 0, 0, 1);
        issue(3'b100, 6'b111111, 0, 0, 1);
        issue(3'b000, 6'b011000, 32'hFFFF_FFFD, 32'h0000_0007, 1);
        issue(3'b000, 6'b010010, 0, 0, 1);
        issue(3'b000, 6'b010000, 0, 0, 1);
        issue(3'b000, 6'b011011, 32'd100, 32'd7, 1);
        issue(3'b000, 6'b011010, 32'hFFFF_FFF9, 32'd2, 1);
        issue(3'b000, 6'b011010, 32'd5, 32'd0, 1);
        issue(3'b000, 6'b011001, 32'd2, 32'd3, 1);
        issue(3'b000, 6'b011010, 32'hFFFF_FFFB, 32'd0, 1);
        issue(3'b000, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(3'b000, 6'b010001, 32'hDEAD_BEEF, 0, 1);
        issue(3'b000, 6'b010011, 32'h1234_5678, 0, 1);
        issue(3'b000, 6'b010000, 0, 0, 1);
        issue(3'b000, 6'b111111, 0, 0, 1);
        drain();

        // Reset during RUN cycle 10 discards the operation.
        issue(3'b000, 6'b011000, 32'h0000_1234, 32'h0000_5678, 0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("busy_before_reset", {63'b0, bus.mdu_busy}, 1);
        @(negedge clk);
        #1;
        check("mid_rst_busy", {63'b0, bus.mdu_busy}, 0);
        check("mid_rst_in_ready", {63'b0, bus.in_ready}, 1);
        check("mid_rst_hi", {32'b0, bus.hi}, 0);
        check("mid_rst_lo", {32'b0, bus.lo}, 0);
        check("mid_rst_op_valid", {63'b0, bus.op_valid}, 0);
        m_hi = '0;
        m_lo = '0;
        m_dbz = 0;
        rst_n = 1'b1;

        repeat (250) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 21)];
            issue(a, f, rnd_val(), rnd_val(), 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_control_mdu.md
# alu_control_mdu

Registered, parametrised successor to the EX-stage ALU control decoder. It maps `alu_op` and `funct` to the 4-bit ALU operation code, with immediate forms decoded from `alu_op` rather than `funct`. It adds an iterative multiply/divide sequencer with HI/LO registers and stalls upstream through `in_ready`. It sits between the ID/EX pipeline register and the ALU/writeback mux.

## Interface
- `DATA_W`, 32: operand, HI and LO width; also the iteration count.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  EX instruction present.
- `in_ready`  out  1  equals `!mdu_busy`; an instruction transfers when `in_valid && in_ready`.
- `alu_op`  in  3  main-control class.
- `funct`  in  6  R-type function field.
- `rs_val`, `rt_val`  in  DATA_W  mult/div operands, and `rs_val` as the mthi/mtlo source.
- `op`  out  4  registered ALU op code.
- `op_valid`  out  1  `op` is meaningful this cycle.
- `hilo_sel`  out  2  `10` selects HI and `01` selects LO for mfhi/mflo; `00` otherwise.
- `illegal`  out  1  one-cycle pulse for an undefined funct.
- `mdu_busy`  out  1  sequencer running.
- `hi`, `lo`  out  DATA_W  architectural HI and LO.
- `div_by_zero`  out  1  last division had a zero divisor.

## Operation
- ALU op codes: and 0000, or 0001, xor 0010, nor 0011, add 0101, sub 0110, slt 0111, srl 1000, sll 1001, sra 1010, move-from 1111.
- `alu_op` decode:
  - 000: R-type, decoded from `funct`.
  - 001 addi → 0101; 010 beq/bne → 0110; 011 slti → 0111; 100 lw/sw → 0101; 101 andi → 0000; 110 ori → 0001; 111 xori → 0010.
- R-type `funct` decode:
  - 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt; 000000 sll; 000010 srl; 000011 sra.
  - 010000 mfhi and 010010 mflo: op 1111 with `hilo_sel` set.
  - 010001 mthi and 010011 mtlo: write HI or LO from `rs_val`; `op_valid` 0.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu: start the sequencer; `op_valid` 0.
  - Any other value: `illegal` 1, `op_valid` 0, `op` 0101.
- Sequencer states:
  - IDLE → RUN on an accepted mult/div.
  - RUN lasts DATA_W cycles, one shift-add or restoring-subtract iteration per cycle on operand magnitudes.
  - FIX lasts 1 cycle: sign correction, then write HI and LO; → IDLE.
- Signed results:
  - mult: the 2·DATA_W product is negated when operand signs differ; HI is the upper half, LO the lower half.
  - div: LO = quotient, HI = remainder; quotient sign is the XOR of the operand signs, remainder sign follows the dividend.
- Divide by zero (div or divu): no iteration fault. Result is HI = dividend, LO = all ones, `div_by_zero` 1. The flag clears on the next mult/div start.
- Reset values: `op` 0, `op_valid` 0, `hilo_sel` 00, `illegal` 0, `mdu_busy` 0, `hi` 0, `lo` 0, `div_by_zero` 0, state IDLE.

## Timing
- Non-MDU transfer in cycle N: `op`, `op_valid`, `hilo_sel` and `illegal` are valid in cycle N+1 and held for one cycle. Idle cycles drive `op_valid` 0.
- mthi/mtlo in cycle N: the new HI/LO value is visible in cycle N+1.
- mult/div accepted in cycle N:
  - `mdu_busy` 1 in cycles N+1 … N+DATA_W+1.
  - HI/LO are written at the end of FIX and visible in cycle N+DATA_W+2, when `mdu_busy` falls.
- While busy, `in_ready` is 0. Nothing is accepted, including mfhi/mflo/mthi/mtlo; the upstream stage holds its inputs.
- Operands are captured at acceptance; later changes on `rs_val`/`rt_val` are ignored.
- Back-to-back: a new instruction is accepted in the first cycle `mdu_busy` is 0.
- `rst_n` low in any state, including mid-RUN: on the next edge every output takes its reset value and the operation is discarded.

## Structure
- Package `alu_pkg` holds:
  - ALU op code constants;
  - `alu_op` class constants;
  - funct constants;
  - sequencer state encoding (IDLE, RUN, FIX).
- Sub-module `mdu_seq` holds the iterative mult/div datapath, counter, state machine and sign fix. The top level keeps the decode, output registers and handshake.

## Test plan
- R-type `alu_op` 000 with `funct` 100100, then 100111, then 000011 → `op` 0000, then 0011, then 1010, each one cycle after acceptance, `op_valid` 1.
- `alu_op` 110 with `funct` 101010 → `op` 0001 (funct ignored). `alu_op` 010 → 0110; `alu_op` 100 → 0101.
- mult `rs_val` FFFFFFFD, `rt_val` 00000007 → `in_ready` 0 for 33 cycles, then `hi` FFFFFFFF, `lo` FFFFFFEB. A following mflo gives `op` 1111, `hilo_sel` 01.
- divu 100/7 → `lo` 0000000E, `hi` 00000002. div −7/2 → `lo` FFFFFFFD, `hi` FFFFFFFF.
- div 5/0 → `hi` 00000005, `lo` FFFFFFFF, `div_by_zero` 1. A following multu 2×3 clears the flag; `lo` 00000006.
- `rst_n` low in RUN cycle 10 → next cycle `mdu_busy` 0, `in_ready` 1, `hi`/`lo` 0. `funct` 111111 → `illegal` 1 for one cycle, `op_valid` 0.
